scan_chain_loader: RTL
======================

# scan_chain_loader

Scan-chain controller that drives the configuration scan chain of the FPGA fabric from its `scan_in`/`scan_en` end. It serializes configuration words from an upstream bitstream source into the chain, and reads the chain back through `scan_out` without destroying it. It sits between the configuration interface and the first/last tile registers of the chain, and is the only block that drives `scan_en`.

## Interface
- `CHAIN_LEN`, 64: total scan-chain length in bits; must be ≥1.
- `WORD_W`, 8: width of data words on both streaming ports; must be ≥2.
- `clk` input 1: single clock; the chain and the controller share it.
- `rst` input 1: asynchronous, active-high reset.
- `cmd_load` input 1: one-cycle request to start a load pass.
- `cmd_read` input 1: one-cycle request to start a readback pass.
- `in_data` input WORD_W: configuration word, MSB shifted first.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: word accepted when `in_valid && in_ready`.
- `out_data` output WORD_W: readback word, first-read bit at MSB.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: downstream accepts the word.
- `scan_in` output 1: serial data into the chain head.
- `scan_en` output 1: chain shift enable.
- `scan_out` input 1: chain tail bit; a register output, so combinational use is loop-free.
- `busy` output 1: a pass is in progress.
- `done` output 1: one-cycle pulse at the end of a pass.

## Operation
- States: IDLE, LOAD, READ, DONE. Reset forces IDLE. All outputs are 0 at reset.
- IDLE:
  - `cmd_load` goes to LOAD.
  - `cmd_read` goes to READ.
  - If both are asserted, `cmd_load` wins.
  - Commands outside IDLE are ignored.
- LOAD:
  - The word buffer holds one word plus a bit index.
  - `in_ready` = buffer empty, or buffer shifting its last used bit this cycle. This gives gapless back-to-back words.
  - Each cycle the buffer holds a bit, the controller registers `scan_en`=1 and `scan_in`=the current MSB-side bit.
  - When the buffer is empty, the registered `scan_en` is 0. The chain stalls and holds its state.
- Bit counter:
  - Counts shifted bits, width `$clog2(CHAIN_LEN+1)`.
  - After CHAIN_LEN bits, no further words are accepted. The pass goes to DONE.
- Partial last word: the load consumes ceil(CHAIN_LEN/WORD_W) words. In the last word only the top CHAIN_LEN mod WORD_W bits are shifted; the low bits are discarded.
- READ:
  - `scan_in` = `scan_out` combinationally, so the chain recirculates and is unchanged after CHAIN_LEN shifts.
  - At each edge with `scan_en`=1, `scan_out` is captured into the assembly register, MSB first.
  - After WORD_W captures, or after the final bit, the word is presented on `out_data`/`out_valid`. The last word is left-aligned and zero-padded.
  - While `out_valid && !out_ready`, `scan_en` is 0 and no capture occurs.
- Bit order: the first bit loaded is the first bit read back, so a read returns the load stream.
- DONE: `done`=1 for one cycle, `scan_en`=0, then IDLE. `busy`=1 in LOAD and READ.

## Timing
- LOAD latency:
  - Word accepted at edge N → first `scan_en`/`scan_in` valid after edge N+1.
  - The chain samples that bit at edge N+2.
- With `in_valid` held high, `scan_en` is high for exactly CHAIN_LEN consecutive cycles.
- READ: `scan_en` rises the cycle after `cmd_read`. Each word's `out_valid` rises the cycle after its final capture edge.
- `done` is asserted the cycle after the final shift edge, or after the final word handshake in READ.
- Reset mid-pass:
  - `scan_en` deasserts immediately (asynchronous).
  - Chain contents are left partial.
  - No `done` pulse.
  - The buffered word is lost.
- `in_valid` dropping mid-pass stalls the pass indefinitely. There is no timeout.

## Structure
- A shared header/package holds the state encodings (2 bits), the `WORD_W`/`CHAIN_LEN` defaults, and the count-width function.
- Sub-module `scan_word_shifter`: a one-word parallel-load/serial-shift register with a bit index and load/capture modes. It is used twice: as the LOAD serializer and the READ deserializer.
- Top level holds the FSM, the bit counter, handshake logic and the `scan_in` mux.

## Test plan
- CHAIN_LEN=12, WORD_W=8, load 0xA5, 0x3C with `in_valid` always high → `scan_in` sequence 1,0,1,0,0,1,0,1,0,0,1,1 on 12 consecutive `scan_en` cycles; one `done`; second word's low 4 bits unused.
- Load as above, then `cmd_read` with `out_ready`=1 → `out_data` 0xA5 then 0x30; chain model contents identical before and after.
- Read with `out_ready` low for 5 cycles after the first word → `scan_en` low for exactly those cycles; words are unchanged.
- `in_valid` gaps of 3 cycles between words → `scan_en` low during the gaps; the total count of high cycles is still 12.
- `rst` asserted mid-load after 5 bits → `scan_en`/`busy` drop in the same cycle, no `done`; a subsequent full load is correct.
- `cmd_read` during LOAD, and `cmd_load`+`cmd_read` together in IDLE → the busy-time command is ignored; the simultaneous case starts LOAD.

Source files
------------

// File: rtl/scan_chain_loader_pkg.sv
// Shared definitions for the scan-chain loader: controller state encoding,
// default geometry and the counter-width helper.
package scan_chain_loader_pkg;

  localparam int CHAIN_LEN_DEF = 64;
  localparam int WORD_W_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_word_shifter.sv
// One-word shift register with a bit index.
//   load    : parallel load din, index to 0 (serializer side)
//   shift   : shift left one bit, index+1; MSB is the outgoing bit
//   capture : write bit_in at position WORD_W-1-index, index+1 (deserializer);
//             with clear also set, the word restarts from empty in the same edge
//   clear   : word and index to 0
// Ports: clk, rst (async high), load, din, shift, clear, capture, bit_in,
//        word (current contents), idx (bits shifted/captured so far).
module scan_word_shifter #(
  parameter  int WORD_W = 8,
  localparam int IW     = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] din,
  input  logic              shift,
  input  logic              clear,
  input  logic              capture,
  input  logic              bit_in,
  output logic [WORD_W-1:0] word,
  output logic [IW-1:0]     idx
);

  logic [WORD_W-1:0] base_w, cap_w;
  logic [IW-1:0]     base_i;

  // Captures land MSB first, so a short final word ends up left-aligned
  // with zero padding below it.
  always_comb begin
    base_w = clear ? '0 : word;
    base_i = clear ? '0 : idx;
    cap_w  = base_w;
    for (int i = 0; i < WORD_W; i++)
      if (base_i == IW'(WORD_W - 1 - i)) cap_w[i] = bit_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      idx  <= '0;
    end else if (load) begin
      word <= din;
      idx  <= '0;
    end else if (capture) begin
      word <= cap_w;
      idx  <= base_i + IW'(1);
    end else if (shift) begin
      word <= {word[WORD_W-2:0], 1'b0};
      idx  <= idx + IW'(1);
    end else if (clear) begin
      word <= '0;
      idx  <= '0;
    end
  end

endmodule

// File: rtl/scan_chain_loader.sv
// Scan-chain controller. Serializes configuration words into the chain head
// (LOAD) and reads the chain back through its tail while recirculating it
// (READ), so a readback leaves the chain unchanged.
// Ports: clk, rst (async high); cmd_load/cmd_read pass requests;
//        in_data/in_valid/in_ready load stream; out_data/out_valid/out_ready
//        readback stream; scan_in/scan_en/scan_out chain port; busy, done.
module scan_chain_loader
  import scan_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int WORD_W    = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_load,
  input  logic              cmd_read,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              scan_in,
  output logic              scan_en,
  input  logic              scan_out,
  output logic              busy,
  output logic              done
);

  localparam int CW = cnt_w(CHAIN_LEN);
  localparam int IW = $clog2(WORD_W + 1);

  state_t            state, state_nx;
  logic [CW-1:0]     bit_cnt;
  logic [IW-1:0]     buf_left;      // bits of the buffered word still to shift
  logic              scan_en_q, scan_in_q, out_valid_q;
  logic              ld_shift, accept, rd_en, hs, rd_full;
  int                committed, new_len, rd_idx_nx;
  logic [WORD_W-1:0] ser_word, des_word;
  logic [IW-1:0]     ser_idx, des_idx;
  logic              unused_ser;

  assign ld_shift = (state == ST_LOAD) && (buf_left != '0);
  assign hs       = out_valid_q && out_ready;

  always_comb begin
    // Bits shifted plus bits still held: the chain positions already claimed.
    committed = int'(bit_cnt) + int'(buf_left);
    new_len   = CHAIN_LEN - committed;
    if (new_len > WORD_W) new_len = WORD_W;
  end

  // Ready when empty or on the buffer's last bit, so words follow gaplessly.
  assign in_ready = (state == ST_LOAD) &&
                    (buf_left == '0 || buf_left == IW'(1)) &&
                    (committed < CHAIN_LEN);
  assign accept   = in_valid && in_ready;

  // A presented word blocks shifting until it is taken; on the handshake
  // cycle the next capture restarts the assembly register.
  assign rd_en = (state == ST_READ) && (bit_cnt != CW'(CHAIN_LEN)) &&
                 (!out_valid_q || out_ready);

  always_comb begin
    rd_idx_nx = (hs ? 0 : int'(des_idx)) + 1;
    rd_full   = rd_en && (rd_idx_nx == WORD_W || int'(bit_cnt) + 1 == CHAIN_LEN);
  end

  scan_word_shifter #(.WORD_W(WORD_W)) u_ser (
    .clk(clk), .rst(rst), .load(accept), .din(in_data), .shift(ld_shift),
    .clear(1'b0), .capture(1'b0), .bit_in(1'b0), .word(ser_word), .idx(ser_idx)
  );

  scan_word_shifter #(.WORD_W(WORD_W)) u_des (
    .clk(clk), .rst(rst), .load(1'b0), .din('0), .shift(1'b0),
    .clear(state == ST_IDLE || hs), .capture(rd_en), .bit_in(scan_out),
    .word(des_word), .idx(des_idx)
  );

  // Only the outgoing MSB of the serializer matters here.
  assign unused_ser = &{1'b0, ser_word[WORD_W-2:0], ser_idx};

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (cmd_load)      state_nx = ST_LOAD;
               else if (cmd_read) state_nx = ST_READ;
      ST_LOAD: if (bit_cnt == CW'(CHAIN_LEN)) state_nx = ST_DONE;
      ST_READ: if (bit_cnt == CW'(CHAIN_LEN) && hs) state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      buf_left    <= '0;
      scan_en_q   <= 1'b0;
      scan_in_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state     <= state_nx;
      scan_en_q <= ld_shift;
      scan_in_q <= ld_shift & ser_word[WORD_W-1];
      if (state == ST_IDLE)       bit_cnt <= '0;
      else if (ld_shift || rd_en) bit_cnt <= bit_cnt + CW'(1);
      if (accept)        buf_left <= IW'(new_len);
      else if (ld_shift) buf_left <= buf_left - IW'(1);
      if (state != ST_READ) out_valid_q <= 1'b0;
      else                  out_valid_q <= rd_full || (out_valid_q && !out_ready);
    end
  end

  // In READ the tail feeds the head directly so the chain recirculates.
  assign scan_in   = (state == ST_READ) ? scan_out : scan_in_q;
  assign scan_en   = scan_en_q | rd_en;
  assign out_data  = des_word;
  assign out_valid = out_valid_q;
  assign busy      = (state == ST_LOAD) || (state == ST_READ);
  assign done      = (state == ST_DONE);

endmodule
